alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_rr_grant.sv | 15 +
 rtl/alu_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ALU opcodes and FSM state type for alu_arbiter (MUL state present when ALU_ARBITER_MUL_EN is defined)
package alu_arbiter_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
`ifdef ALU_ARBITER_MUL_EN
        MUL  = 2'd2,
`endif
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// rtl/alu_rr_grant.sv - two-way round-robin grant; pointer picks the winner only when both requesters are valid
module alu_rr_grant (
    input  logic valid_0,
    input  logic valid_1,
    input  logic pointer,
    output logic grant_0,
    output logic grant_1
);

    always_comb begin
        grant_0 = valid_0 && (!valid_1 || !pointer);
        grant_1 = valid_1 && (!valid_0 || pointer);
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters; ALU_ARBITER_MUL_EN adds an iterative shift-add multiply
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter logic [3:0] MUL_OP = 4'b1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [31:0] req_a_0,
    input  logic [31:0] req_b_0,
    input  logic [3:0]  req_op_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [31:0] req_a_1,
    input  logic [31:0] req_b_1,
    input  logic [3:0]  req_op_1,
    output logic        resp_valid_0,
    output logic [31:0] resp_result_0,
    output logic        resp_zero_0,
    output logic        resp_cout_0,
    output logic        resp_valid_1,
    output logic [31:0] resp_result_1,
    output logic        resp_zero_1,
    output logic        resp_cout_1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_cout
);

    state_t      state, state_nx;
    logic        pointer;
    logic        owner;
    logic        grant_0, grant_1;
    logic        hs_0, hs_1, start;
    logic [31:0] sel_a, sel_b;
    logic [3:0]  sel_op;
    logic        is_mul;
    logic        cap_en;
    logic [31:0] cap_result;
    logic        cap_zero, cap_cout;
`ifdef ALU_ARBITER_MUL_EN
    logic [31:0] mplier;
    logic [4:0]  mul_cnt;
`endif

    alu_rr_grant u_grant (
        .valid_0 (req_valid_0),
        .valid_1 (req_valid_1),
        .pointer (pointer),
        .grant_0 (grant_0),
        .grant_1 (grant_1)
    );

    assign req_ready_0 = (state == IDLE) && grant_0 && !rst;
    assign req_ready_1 = (state == IDLE) && grant_1 && !rst;
    assign hs_0        = req_valid_0 && req_ready_0;
    assign hs_1        = req_valid_1 && req_ready_1;
    assign start       = hs_0 || hs_1;
    assign sel_a       = hs_1 ? req_a_1  : req_a_0;
    assign sel_b       = hs_1 ? req_b_1  : req_b_0;
    assign sel_op      = hs_1 ? req_op_1 : req_op_0;
    assign is_mul      = (sel_op == MUL_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ALU_ARBITER_MUL_EN
                    state_nx = is_mul ? MUL : EXEC;
`else
                    state_nx = EXEC;
`endif
                end
            end
            EXEC: state_nx = RESP;
`ifdef ALU_ARBITER_MUL_EN
            MUL: begin
                if (mul_cnt == 5'd31) begin
                    state_nx = RESP;
                end
            end
`endif
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The final multiply step folds its own add into the captured result.
    always_comb begin
        cap_en     = (state == EXEC);
        cap_result = alu_result;
        cap_zero   = alu_zero;
        cap_cout   = alu_cout;
`ifdef ALU_ARBITER_MUL_EN
        if ((state == MUL) && (mul_cnt == 5'd31)) begin
            cap_en     = 1'b1;
            cap_result = mplier[0] ? alu_result : alu_a;
            cap_zero   = (cap_result == 32'd0);
            cap_cout   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pointer       <= 1'b0;
            owner         <= 1'b0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_op        <= 4'b0000;
            resp_valid_0  <= 1'b0;
            resp_result_0 <= 32'd0;
            resp_zero_0   <= 1'b0;
            resp_cout_0   <= 1'b0;
            resp_valid_1  <= 1'b0;
            resp_result_1 <= 32'd0;
            resp_zero_1   <= 1'b0;
            resp_cout_1   <= 1'b0;
`ifdef ALU_ARBITER_MUL_EN
            mplier        <= 32'd0;
            mul_cnt       <= 5'd0;
`endif
        end else begin
            resp_valid_0 <= cap_en && !owner;
            resp_valid_1 <= cap_en && owner;
            if (cap_en && !owner) begin
                resp_result_0 <= cap_result;
                resp_zero_0   <= cap_zero;
                resp_cout_0   <= cap_cout;
            end
            if (cap_en && owner) begin
                resp_result_1 <= cap_result;
                resp_zero_1   <= cap_zero;
                resp_cout_1   <= cap_cout;
            end
            if (start) begin
                owner   <= hs_1;
                pointer <= !hs_1;
                alu_a   <= sel_a;
                alu_b   <= sel_b;
`ifdef ALU_ARBITER_MUL_EN
                alu_op  <= sel_op;
                // alu_a doubles as the accumulator and alu_b as the shifting multiplicand.
                if (is_mul) begin
                    alu_a   <= 32'd0;
                    alu_b   <= sel_a;
                    alu_op  <= OP_ADD;
                    mplier  <= sel_b;
                    mul_cnt <= 5'd0;
                end
`else
                alu_op  <= is_mul ? MUL_OP : sel_op;
`endif
            end
`ifdef ALU_ARBITER_MUL_EN
            if (state == MUL) begin
                if (mplier[0]) begin
                    alu_a <= alu_result;
                end
                alu_b   <= alu_b << 1;
                mplier  <= mplier >> 1;
                mul_cnt <= mul_cnt + 5'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter with a behavioural ALU and arbitration model
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

`ifdef ALU_ARBITER_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [3:0]  op [2];
    logic        req_ready_0, req_ready_1;
    logic        resp_valid_0, resp_zero_0, resp_cout_0;
    logic        resp_valid_1, resp_zero_1, resp_cout_1;
    logic [31:0] resp_result_0, resp_result_1;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero, alu_cout;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int          s_cyc;
    logic        s_v [2], s_rdy [2], s_hs [2], s_rv [2], s_z [2], s_c [2];
    logic [31:0] s_a [2], s_b [2], s_res [2];
    logic [3:0]  s_op [2];
    logic [31:0] s_alu_a, s_alu_b;
    logic [3:0]  s_alu_op;
    bit          gq [$];
    int          gcyc [$];
    bit          e_k;
    logic [32:0] e_val;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_OP(OP_MUL)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(v[0]), .req_ready_0(req_ready_0), .req_a_0(a[0]), .req_b_0(b[0]), .req_op_0(op[0]),
        .req_valid_1(v[1]), .req_ready_1(req_ready_1), .req_a_1(a[1]), .req_b_1(b[1]), .req_op_1(op[1]),
        .resp_valid_0(resp_valid_0), .resp_result_0(resp_result_0), .resp_zero_0(resp_zero_0), .resp_cout_0(resp_cout_0),
        .resp_valid_1(resp_valid_1), .resp_result_1(resp_result_1), .resp_zero_1(resp_zero_1), .resp_cout_1(resp_cout_1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout)
    );

    // Textbook ALU semantics, returned as {cout, result}.
    function automatic logic [32:0] alu_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        case (o)
            OP_AND:  return {1'b0, x & y};
            OP_OR:   return {1'b0, x | y};
            OP_ADD:  return {1'b0, x} + {1'b0, y};
            OP_SUB:  return {(x >= y), x - y};
            OP_SLT:  return {1'b0, 31'd0, ($signed(x) < $signed(y))};
            OP_NOR:  return {1'b0, ~(x | y)};
            default: return 33'd0;
        endcase
    endfunction

    function automatic logic [32:0] exp_fn(input logic [31:0] x, input logic [31:0] y, input logic [3:0] o);
        logic [31:0] p;
        p = x * y;
        if (MUL_EN && (o == OP_MUL)) return {1'b0, p};
        return alu_fn(x, y, o);
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        return (MUL_EN && (o == OP_MUL)) ? 33 : 2;
    endfunction

    always_comb begin
        {alu_cout, alu_result} = alu_fn(alu_a, alu_b, alu_op);
        alu_zero = (alu_result == 32'd0);
    end

    task automatic new_op(input int k, input bit allow_mul);
        logic [3:0] ops [6];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
        a[k]  = $urandom;
        b[k]  = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
        op[k] = ops[$urandom_range(0, 5)];
        if (allow_mul && ($urandom_range(0, 7) == 0)) begin
            op[k] = OP_MUL;
            b[k]  = $urandom_range(0, 1000);
        end
        v[k] = 1'b1;
    endtask

    // Sample one cycle at the falling edge, then advance past the rising edge.
    task automatic step(input bit keep);
        @(negedge clk);
        s_cyc = cyc;
        cyc++;
        s_rdy[0] = req_ready_0;   s_rdy[1] = req_ready_1;
        s_rv[0]  = resp_valid_0;  s_rv[1]  = resp_valid_1;
        s_res[0] = resp_result_0; s_res[1] = resp_result_1;
        s_z[0]   = resp_zero_0;   s_z[1]   = resp_zero_1;
        s_c[0]   = resp_cout_0;   s_c[1]   = resp_cout_1;
        s_alu_a = alu_a; s_alu_b = alu_b; s_alu_op = alu_op;
        for (int k = 0; k < 2; k++) begin
            s_v[k] = v[k]; s_a[k] = a[k]; s_b[k] = b[k]; s_op[k] = op[k];
            s_hs[k] = v[k] && s_rdy[k];
            if (s_hs[k]) begin
                gq.push_back(k == 1);
                gcyc.push_back(s_cyc);
                e_k = (k == 1);
                e_val = exp_fn(a[k], b[k], op[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (s_hs[k]) begin
                if (keep) new_op(k, 1'b0);
                else v[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        v[0] = 1'b0; v[1] = 1'b0;
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
    endtask

    task automatic run_single(input int k, input logic [31:0] x, input logic [31:0] y, input logic [3:0] o,
                              output bit seen, output int lat, output logic [31:0] res, output logic z,
                              output logic c, output logic [3:0] op1, output logic [3:0] op5);
        int hc;
        seen = 1'b0; lat = -1; res = '0; z = 1'b0; c = 1'b0; op1 = '0; op5 = '0;
        a[k] = x; b[k] = y; op[k] = o; v[k] = 1'b1;
        step(1'b0);
        hc = s_cyc;
        if (!s_hs[k]) v[k] = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step(1'b0);
            if (s_cyc == hc + 1) op1 = s_alu_op;
            if (s_cyc == hc + 5) op5 = s_alu_op;
            if (s_rv[k] && !seen) begin
                seen = 1'b1; lat = s_cyc - hc; res = s_res[k]; z = s_z[k]; c = s_c[k];
            end
        end
    endtask

    task automatic test_reset();
        a[0] = 32'd3; b[0] = 32'd4; op[0] = OP_ADD; v[0] = 1'b1;
        step(1'b0);
        n_total++; if (s_rdy[0] !== 1'b0) $display("FAIL reset_ready0 got %b exp 0", s_rdy[0]); else n_pass++;
        n_total++; if ({s_rv[0], s_rv[1]} !== 2'b00) $display("FAIL reset_resp_valid got %b%b exp 00", s_rv[0], s_rv[1]); else n_pass++;
        n_total++; if ({s_res[0], s_res[1]} !== 64'd0) $display("FAIL reset_resp_result got %h %h exp 0 0", s_res[0], s_res[1]); else n_pass++;
        n_total++; if ({s_z[0], s_z[1], s_c[0], s_c[1]} !== 4'b0000) $display("FAIL reset_flags got %b%b%b%b exp 0000", s_z[0], s_z[1], s_c[0], s_c[1]); else n_pass++;
        n_total++; if ({s_alu_a, s_alu_b, s_alu_op} !== 68'd0) $display("FAIL reset_alu_ports got %h %h %h exp 0 0 0", s_alu_a, s_alu_b, s_alu_op); else n_pass++;
        v[0] = 1'b0;
        rst = 1'b0;
        step(1'b0);
    endtask

    task automatic test_single_add();
        a[0] = 32'd5; b[0] = 32'd7; op[0] = OP_ADD; v[0] = 1'b1;
        step(1'b0);
        n_total++; if (s_rdy[0] !== 1'b1) $display("FAIL add_ready0 got %b exp 1", s_rdy[0]); else n_pass++;
        step(1'b0);
        n_total++; if (s_alu_op !== OP_ADD) $display("FAIL add_alu_op got %b exp 0010", s_alu_op); else n_pass++;
        n_total++; if (s_rv[0] !== 1'b0) $display("FAIL add_early_resp got %b exp 0", s_rv[0]); else n_pass++;
        step(1'b0);
        n_total++; if ({s_rv[0], s_rv[1]} !== 2'b10) $display("FAIL add_resp_valid got %b%b exp 10", s_rv[0], s_rv[1]); else n_pass++;
        n_total++; if ({s_res[0], s_z[0]} !== {32'd12, 1'b0}) $display("FAIL add_result got %0d z%b exp 12 z0", s_res[0], s_z[0]); else n_pass++;
        step(1'b0);
        n_total++; if (s_rv[0] !== 1'b0) $display("FAIL add_resp_one_cycle got %b exp 0", s_rv[0]); else n_pass++;
        n_total++; if (s_res[0] !== 32'd12) $display("FAIL add_result_hold got %0d exp 12", s_res[0]); else n_pass++;
    endtask

    task automatic test_both_valid();
        int seen0, seen1;
        seen0 = 0; seen1 = 0;
        do_reset();
        gq.delete(); gcyc.delete();
        a[0] = 32'd9;    b[0] = 32'd9;    op[0] = OP_SUB; v[0] = 1'b1;
        a[1] = 32'h0F0;  b[1] = 32'h00F;  op[1] = OP_OR;  v[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (s_rv[0]) begin
                seen0++;
                n_total++; if ({s_res[0], s_z[0]} !== {32'd0, 1'b1}) $display("FAIL both_req0 got %h z%b exp 0 z1", s_res[0], s_z[0]); else n_pass++;
                n_total++; if (s_rv[1] !== 1'b0) $display("FAIL both_rv1_during_rv0 got %b exp 0", s_rv[1]); else n_pass++;
            end
            if (s_rv[1]) begin
                seen1++;
                n_total++; if ({s_res[1], s_z[1]} !== {32'hFF, 1'b0}) $display("FAIL both_req1 got %h z%b exp ff z0", s_res[1], s_z[1]); else n_pass++;
            end
        end
        n_total++; if (!(gq.size() == 2 && gq[0] == 1'b0 && gq[1] == 1'b1)) $display("FAIL both_order got %0d grants first %0d exp 2 grants 0 then 1", gq.size(), (gq.size() > 0) ? int'(gq[0]) : -1); else n_pass++;
        n_total++; if ({seen0, seen1} !== {32'd1, 32'd1}) $display("FAIL both_resp_count got %0d,%0d exp 1,1", seen0, seen1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nresp;
        nresp = 0;
        do_reset();
        gq.delete(); gcyc.delete();
        new_op(0, 1'b0);
        new_op(1, 1'b0);
        for (int i = 0; i < 30 && gq.size() < 4; i++) begin
            step(1'b1);
            for (int k = 0; k < 2; k++) begin
                if (s_rv[k]) begin
                    nresp++;
                    n_total++; if ({s_c[k], s_res[k]} !== e_val || k != int'(e_k)) $display("FAIL b2b_resp%0d got %h c%b exp %h owner %0d", k, s_res[k], s_c[k], e_val[31:0], e_k); else n_pass++;
                end
            end
        end
        v[0] = 1'b0; v[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            for (int k = 0; k < 2; k++) begin
                if (s_rv[k]) begin
                    nresp++;
                    n_total++; if ({s_c[k], s_res[k]} !== e_val || k != int'(e_k)) $display("FAIL b2b_resp%0d got %h c%b exp %h owner %0d", k, s_res[k], s_c[k], e_val[31:0], e_k); else n_pass++;
                end
            end
        end
        n_total++; if (!(gq.size() == 4 && gq[0] == 1'b0 && gq[1] == 1'b1 && gq[2] == 1'b0 && gq[3] == 1'b1))
            $display("FAIL b2b_alternate got %0d grants exp 0,1,0,1", gq.size()); else n_pass++;
        n_total++; if (!(gcyc.size() == 4 && gcyc[1] - gcyc[0] == 3 && gcyc[3] - gcyc[2] == 3))
            $display("FAIL b2b_throughput got %0d grants spacing exp 3 cycles", gcyc.size()); else n_pass++;
        n_total++; if (nresp !== 4) $display("FAIL b2b_resp_count got %0d exp 4", nresp); else n_pass++;
    endtask

    task automatic test_random();
        bit          m_ptr, m_own, m_live, eg [2];
        int          m_due;
        logic [32:0] m_val;
        m_ptr = 1'b0; m_own = 1'b0; m_live = 1'b0; m_due = -1; m_val = '0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!v[k] && $urandom_range(0, 2) == 0) new_op(k, 1'b1);
            end
            step(1'b0);
            for (int k = 0; k < 2; k++) begin
                n_total++; if (s_rv[k] !== (m_live && s_cyc == m_due && int'(m_own) == k))
                    $display("FAIL rand_resp_valid%0d cyc %0d got %b exp %b", k, s_cyc, s_rv[k], m_live && s_cyc == m_due && int'(m_own) == k); else n_pass++;
                if (s_rv[k] && m_live && s_cyc == m_due) begin
                    n_total++; if ({s_c[k], s_z[k], s_res[k]} !== {m_val[32], m_val[31:0] == 32'd0, m_val[31:0]})
                        $display("FAIL rand_result%0d got %h z%b c%b exp %h", k, s_res[k], s_z[k], s_c[k], m_val[31:0]); else n_pass++;
                end
            end
            for (int k = 0; k < 2; k++) begin
                eg[k] = (s_cyc > m_due) && s_v[k] && (!s_v[1-k] || int'(m_ptr) == k);
                n_total++; if (s_rdy[k] !== eg[k]) $display("FAIL rand_ready%0d cyc %0d got %b exp %b", k, s_cyc, s_rdy[k], eg[k]); else n_pass++;
            end
            for (int k = 0; k < 2; k++) begin
                if (eg[k]) begin
                    m_live = 1'b1; m_own = (k == 1); m_ptr = (k == 0);
                    m_due = s_cyc + exp_lat(s_op[k]);
                    m_val = exp_fn(s_a[k], s_b[k], s_op[k]);
                end
            end
        end
        v[0] = 1'b0; v[1] = 1'b0;
        repeat (40) step(1'b0);
    endtask

`ifdef ALU_ARBITER_MUL_EN
    task automatic test_mul();
        bit seen; int lat; logic [31:0] res; logic z, c; logic [3:0] op1, op5;
        run_single(0, 32'hFFFF_FFFF, 32'd2, OP_MUL, seen, lat, res, z, c, op1, op5);
        n_total++; if (!seen || lat != 33) $display("FAIL mul_latency got %0d exp 33", lat); else n_pass++;
        n_total++; if ({res, z, c} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) $display("FAIL mul_wrap got %h z%b c%b exp fffffffe z0 c0", res, z, c); else n_pass++;
        n_total++; if (op5 !== OP_ADD) $display("FAIL mul_step_op got %b exp 0010", op5); else n_pass++;
        run_single(1, 32'd6, 32'd7, OP_MUL, seen, lat, res, z, c, op1, op5);
        n_total++; if (!seen || res !== 32'd42) $display("FAIL mul_6x7 got %0d exp 42", res); else n_pass++;
    endtask
`else
    task automatic test_mul();
        bit seen; int lat; logic [3:0] op1, op5; logic [31:0] res; logic z, c;
        run_single(1, 32'd6, 32'd7, OP_MUL, seen, lat, res, z, c, op1, op5);
        n_total++; if (!seen || lat != 2) $display("FAIL mulop_latency got %0d exp 2", lat); else n_pass++;
        n_total++; if (op1 !== OP_MUL) $display("FAIL mulop_forward got %b exp 1000", op1); else n_pass++;
        n_total++; if ({res, z} !== {32'd0, 1'b1}) $display("FAIL mulop_result got %h z%b exp 0 z1", res, z); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        int rv_count;
        bit seen; int lat; logic [31:0] res; logic z, c; logic [3:0] op1, op5;
        rv_count = 0;
        a[0] = 32'd123; b[0] = 32'd456; op[0] = MUL_EN ? OP_MUL : OP_ADD; v[0] = 1'b1;
        step(1'b0);
        n_total++; if (s_hs[0] !== 1'b1) $display("FAIL rstmid_accept got %b exp 1", s_hs[0]); else n_pass++;
        if (MUL_EN) repeat (10) step(1'b0);
        rst = 1'b1;
        a[1] = 32'd1; b[1] = 32'd1; op[1] = OP_ADD; v[1] = 1'b1;
        step(1'b0);
        step(1'b0);
        n_total++; if ({s_rdy[0], s_rdy[1], s_rv[0], s_rv[1]} !== 4'b0000) $display("FAIL rstmid_handshake got rdy %b%b rv %b%b exp 0000", s_rdy[0], s_rdy[1], s_rv[0], s_rv[1]); else n_pass++;
        n_total++; if ({s_alu_a, s_alu_b, s_alu_op} !== 68'd0) $display("FAIL rstmid_alu_ports got %h %h %h exp 0 0 0", s_alu_a, s_alu_b, s_alu_op); else n_pass++;
        n_total++; if ({s_res[0], s_res[1], s_z[0], s_z[1], s_c[0], s_c[1]} !== 68'd0) $display("FAIL rstmid_resp_regs got %h %h exp 0 0", s_res[0], s_res[1]); else n_pass++;
        rst = 1'b0;
        v[1] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            if (s_rv[0] || s_rv[1]) rv_count++;
        end
        n_total++; if (rv_count !== 0) $display("FAIL rstmid_no_resp got %0d exp 0", rv_count); else n_pass++;
        run_single(0, 32'd1, 32'd1, OP_ADD, seen, lat, res, z, c, op1, op5);
        n_total++; if (!seen || lat != 2 || res !== 32'd2) $display("FAIL rstmid_add got %0d lat %0d exp 2 lat 2", res, lat); else n_pass++;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout after %0d cycles", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            v[k] = 1'b0; a[k] = '0; b[k] = '0; op[k] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_add();
        test_both_valid();
        test_back_to_back();
        test_random();
        test_mul();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
